// File: rtl/fp_addsub_pipe.sv
// Pipelined floating-point adder/subtractor: unpack/compare, align, add, normalise/round/pack.
// Subnormals are flushed to zero. Rounding is nearest-even. Flow control is a single global stall.
module fp_addsub_pipe #(
    parameter  int EXP_W  = 8,
    parameter  int FRAC_W = 23,
    localparam int W      = 1 + EXP_W + FRAC_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] s,
    output logic         ovf,
    output logic         unf,
    output logic         inv
);
    localparam int STAGES = 4;
    localparam int MW     = FRAC_W + 4;        // hidden + fraction + G/R/S
    localparam int LZW    = $clog2(MW + 1);
    localparam int XW     = EXP_W + 2;         // signed exponent with headroom
    localparam logic [EXP_W-1:0] EMAX = '1;
    localparam logic [W-1:0] QNAN = {1'b0, EMAX, 1'b1, {(FRAC_W-1){1'b0}}};

    typedef struct packed {
        logic nan;      // result is canonical NaN
        logic inf;      // result is infinity
        logic inf_s;    // sign of that infinity
    } spec_t;

    typedef struct packed {
        logic              sx;
        logic              sub;
        logic [EXP_W-1:0]  ex;
        logic [FRAC_W:0]   mx;
        logic [FRAC_W:0]   my;
        logic [EXP_W-1:0]  d;
        spec_t             sp;
    } s1_t;

    typedef struct packed {
        logic              sx;
        logic              sub;
        logic [EXP_W-1:0]  ex;
        logic [MW-1:0]     xm;
        logic [MW-1:0]     ym;
        spec_t             sp;
    } s2_t;

    typedef struct packed {
        logic              sx;
        logic              sub;
        logic [EXP_W-1:0]  ex;
        logic [MW:0]       sum;
        spec_t             sp;
    } s3_t;

    logic [STAGES:0] vld_pipe;
    logic            adv;
    s1_t             s1_d, s1_q;
    s2_t             s2_d, s2_q;
    s3_t             s3_d, s3_q;
    logic [W-1:0]    res;
    logic            res_ovf, res_unf, res_inv;

    assign adv         = !vld_pipe[STAGES] || out_ready;
    assign in_ready    = adv;
    assign out_valid   = vld_pipe[STAGES];
    assign vld_pipe[0] = in_valid;

    // Valid shift register; everything advances together or holds together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_pipe[STAGES:1] <= '0;
        else if (adv) vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
    end

    // S1: unpack, flush subnormals, classify specials, order by magnitude.
    always_comb begin
        logic             sa, sb, za, zb, ia, ib, na, nb, swap;
        logic [EXP_W-1:0] ea, eb;
        logic [FRAC_W-1:0] fa, fb;
        sa   = a[W-1];
        sb   = b[W-1] ^ op;
        ea   = a[W-2:FRAC_W];
        eb   = b[W-2:FRAC_W];
        za   = (ea == '0);
        zb   = (eb == '0);
        fa   = za ? '0 : a[FRAC_W-1:0];
        fb   = zb ? '0 : b[FRAC_W-1:0];
        ia   = (ea == EMAX) && (fa == '0);
        ib   = (eb == EMAX) && (fb == '0);
        na   = (ea == EMAX) && (fa != '0);
        nb   = (eb == EMAX) && (fb != '0);
        swap = {eb, fb} > {ea, fa};
        s1_d          = '0;
        s1_d.sx       = swap ? sb : sa;
        s1_d.sub      = sa ^ sb;
        s1_d.ex       = swap ? eb : ea;
        s1_d.mx       = swap ? {!zb, fb} : {!za, fa};
        s1_d.my       = swap ? {!za, fa} : {!zb, fb};
        s1_d.d        = swap ? (eb - ea) : (ea - eb);
        s1_d.sp.nan   = na || nb || (ia && ib && (sa != sb));
        s1_d.sp.inf   = ia || ib;
        s1_d.sp.inf_s = ia ? sa : sb;
    end

    // S2: right-align Y, folding every bit shifted past R into sticky.
    always_comb begin
        logic [MW-1:0] yext;
        logic          stk;
        yext = {s1_q.my, 3'b000};
        stk  = |(yext & ~({MW{1'b1}} << s1_q.d));
        s2_d     = '0;
        s2_d.sx  = s1_q.sx;
        s2_d.sub = s1_q.sub;
        s2_d.ex  = s1_q.ex;
        s2_d.xm  = {s1_q.mx, 3'b000};
        s2_d.sp  = s1_q.sp;
        if (int'(s1_q.d) >= MW) s2_d.ym = {{(MW-1){1'b0}}, |s1_q.my};
        else                    s2_d.ym = (yext >> s1_q.d) | {{(MW-1){1'b0}}, stk};
    end

    // S3: magnitude add or subtract; X >= Y so the difference is never negative.
    always_comb begin
        s3_d     = '0;
        s3_d.sx  = s2_q.sx;
        s3_d.sub = s2_q.sub;
        s3_d.ex  = s2_q.ex;
        s3_d.sp  = s2_q.sp;
        s3_d.sum = s2_q.sub ? ({1'b0, s2_q.xm} - {1'b0, s2_q.ym})
                            : ({1'b0, s2_q.xm} + {1'b0, s2_q.ym});
    end

    // S4: normalise, round to nearest even, range check, specials override.
    always_comb begin
        logic [LZW-1:0]       lzc;
        logic                 found, up;
        logic [MW-1:0]        nm;
        logic signed [XW-1:0] en;
        logic [FRAC_W+1:0]    rnd;
        lzc   = '0;
        found = 1'b0;
        for (int i = MW - 1; i >= 0; i--) begin
            if (!found) begin
                if (s3_q.sum[i]) found = 1'b1;
                else             lzc   = lzc + 1'b1;
            end
        end
        if (s3_q.sum[MW]) begin
            nm = {s3_q.sum[MW:2], s3_q.sum[1] | s3_q.sum[0]};
            en = $signed({2'b00, s3_q.ex}) + $signed(XW'(1));
        end else begin
            nm = s3_q.sum[MW-1:0] << lzc;
            en = $signed({2'b00, s3_q.ex}) - $signed({{(XW-LZW){1'b0}}, lzc});
        end
        up  = nm[2] && (nm[1] || nm[0] || nm[3]);
        rnd = {1'b0, nm[MW-1:3]} + {{(FRAC_W+1){1'b0}}, up};
        if (rnd[FRAC_W+1]) en = en + $signed(XW'(1));
        res     = {s3_q.sx, en[EXP_W-1:0], rnd[FRAC_W-1:0]};
        res_ovf = 1'b0;
        res_unf = 1'b0;
        res_inv = 1'b0;
        if (s3_q.sp.nan) begin
            res     = QNAN;
            res_inv = 1'b1;
        end else if (s3_q.sp.inf) begin
            res = {s3_q.sp.inf_s, EMAX, {FRAC_W{1'b0}}};
        end else if (s3_q.sum == '0) begin
            res = {s3_q.sx && !s3_q.sub, {(W-1){1'b0}}};
        end else if (en >= $signed({2'b00, EMAX})) begin
            res     = {s3_q.sx, EMAX, {FRAC_W{1'b0}}};
            res_ovf = 1'b1;
        end else if (en <= $signed(XW'(0))) begin
            res     = {s3_q.sx, {(W-1){1'b0}}};
            res_unf = 1'b1;
        end
    end

    // Datapath stage registers; no reset needed, the valid bits qualify them.
    always_ff @(posedge clk) begin
        if (adv) begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    // Output register holds while stalled and clears on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s   <= '0;
            ovf <= 1'b0;
            unf <= 1'b0;
            inv <= 1'b0;
        end else if (adv && vld_pipe[STAGES-1]) begin
            s   <= res;
            ovf <= res_ovf;
            unf <= res_unf;
            inv <= res_inv;
        end
    end
endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Bench for fp_addsub_pipe: directed vectors plus a small exact-arithmetic reference
// for random operands, checked through an in-order scoreboard.
module tb_fp_addsub_pipe;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         op = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] s;
    logic         ovf, unf, inv;

    fp_addsub_pipe #(.EXP_W(8), .FRAC_W(23)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .ovf(ovf), .unf(unf), .inv(inv)
    );

    always #5 clk = ~clk;

    int           n_assert = 0;
    int           n_fail = 0;
    int           cyc = 0;
    int           stall_left = 0;
    int           last_lat = 0;
    bit           accepted;
    logic [W+2:0] pend_exp;
    logic [W+2:0] sb_q[$];
    int           sb_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // One clock: apply backpressure, sample at negedge, score transfers out then in.
    task automatic tick();
        logic [W+2:0] obs;
        if (stall_left > 0) begin out_ready = 1'b0; stall_left--; end
        else out_ready = 1'b1;
        @(negedge clk);
        obs = {s, ovf, unf, inv};
        if (!out_valid) chk("in_ready_idle", in_ready, 1);
        else if (!out_ready) chk("in_ready_stall", in_ready, 0);
        if (sb_q.size() == 0) chk("no_stale_out", out_valid, 0);
        else if (out_valid) begin
            chk("result", obs, sb_q[0]);
            if (out_ready) begin
                void'(sb_q.pop_front());
                last_lat = cyc - sb_cyc.pop_front();
            end
        end
        if (in_valid && in_ready) begin
            sb_q.push_back(pend_exp);
            sb_cyc.push_back(cyc);
            accepted = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb2, input logic top,
                        input logic [W+2:0] expv);
        a = ta; b = tb2; op = top; pend_exp = expv;
        in_valid = 1'b1;
        accepted = 1'b0;
        for (int k = 0; k < 50 && !accepted; k++) tick();
        chk("accepted", accepted, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 60 && sb_q.size() > 0; k++) tick();
        chk("drained", sb_q.size(), 0);
    endtask

    // Exact reference for normal operands whose exponents differ by at most ~20.
    function automatic logic [W+2:0] model(input logic [31:0] x, input logic [31:0] y,
                                           input logic o);
        int     ex, ey, emin, k, p, e;
        longint mx, my, va, vb, r, mag, q, rem, half;
        bit     sgn;
        logic [31:0] ev;
        ex = int'(x[30:23]); ey = int'(y[30:23]);
        mx = longint'({1'b1, x[22:0]});
        my = longint'({1'b1, y[22:0]});
        emin = (ex < ey) ? ex : ey;
        va = mx << (ex - emin);
        vb = my << (ey - emin);
        r = (x[31] ? -va : va) + ((y[31] ^ o) ? -vb : vb);
        if (r == 0) return '0;
        sgn = (r < 0);
        mag = sgn ? -r : r;
        p = 0;
        for (int i = 0; i < 63; i++) if (mag[i]) p = i;
        if (p > 23) begin
            k = p - 23;
            q = mag >> k;
            rem = mag & ((64'sd1 << k) - 1);
            half = 64'sd1 << (k - 1);
            if (rem > half || (rem == half && q[0])) q++;
            if (q == (64'sd1 << 24)) begin q = q >> 1; k++; end
            e = emin + k;
        end else begin
            q = mag << (23 - p);
            e = emin - (23 - p);
        end
        ev = e;
        return {sgn, ev[7:0], q[22:0], 3'b000};
    endfunction

    task automatic rand_pair(output logic [31:0] x, output logic [31:0] y, output logic o);
        int          ea, eb;
        logic [31:0] r1, r2, e1, e2;
        ea = int'($urandom_range(140, 110));
        eb = ea + int'($urandom_range(40, 0)) - 20;
        r1 = $urandom(); r2 = $urandom();
        e1 = ea; e2 = eb;
        x = {r1[31], e1[7:0], r1[22:0]};
        y = {r2[31], e2[7:0], r2[22:0]};
        o = r1[23];
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic        ro;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_s", s, 0);
        chk("rst_flags", {ovf, unf, inv}, 0);
        chk("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;

        // Basic add with latency check
        send(32'h3F800000, 32'h3F800000, 1'b0, {32'h40000000, 3'b000});
        drain();
        chk("latency", last_lat, 4);

        // Directed stream: cancellation, RNE ties, overflow, invalid, zeros, specials
        send(32'h3F800000, 32'h3F800000, 1'b1, {32'h00000000, 3'b000});
        send(32'h3F800000, 32'h33800000, 1'b0, {32'h3F800000, 3'b000});
        send(32'h3F800001, 32'h33800000, 1'b0, {32'h3F800002, 3'b000});
        send(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, {32'h7F800000, 3'b100});
        send(32'h7F800000, 32'h7F800000, 1'b1, {32'h7FC00000, 3'b001});
        send(32'h00000000, 32'h80000000, 1'b0, {32'h00000000, 3'b000});
        send(32'h80000000, 32'h80000000, 1'b0, {32'h80000000, 3'b000});
        send(32'h7F800001, 32'h3F800000, 1'b0, {32'h7FC00000, 3'b001});
        send(32'h7F800000, 32'h3F800000, 1'b1, {32'h7F800000, 3'b000});
        send(32'h3F800000, 32'h7F800000, 1'b1, {32'hFF800000, 3'b000});
        send(32'h00800001, 32'h00800000, 1'b1, {32'h00000000, 3'b010});
        send(32'h00000001, 32'h3F800000, 1'b0, {32'h3F800000, 3'b000});
        send(32'hC0000000, 32'h3F800000, 1'b0, {32'hBF800000, 3'b000});
        drain();

        // Random stream with a 3-cycle output stall in the middle
        for (int i = 0; i < 6; i++) begin
            rand_pair(ra, rb, ro);
            if (i == 4) stall_left = 3;
            send(ra, rb, ro, model(ra, rb, ro));
        end
        drain();

        // Reset with three operations in flight
        for (int i = 0; i < 3; i++) begin
            rand_pair(ra, rb, ro);
            send(ra, rb, ro, model(ra, rb, ro));
        end
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_s", s, 0);
        sb_q.delete();
        sb_cyc.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(32'h40000000, 32'h3F000000, 1'b0, {32'h40200000, 3'b000});
        drain();
        repeat (6) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/fp_addsub_pipe.md
Name: fp_addsub_pipe

Overview:
- Parametrised, pipelined IEEE-754-style floating-point adder/subtractor.
- Next generation of the team's combinational single-precision add/sub datapath. Adds:
  - configurable exponent and fraction widths
  - a 4-stage pipeline with valid/ready flow control
  - round-to-nearest-even
  - special-value handling (zero, infinity, NaN)
  - exception flags
- Sits between operand-issue logic and the result writeback FIFO.

Parameters:
- EXP_W, 8, exponent field width (bias = 2^(EXP_W-1)-1).
- FRAC_W, 23, stored fraction width (hidden bit excluded).
- W, 1+EXP_W+FRAC_W, total word width. Derived; never overridden.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block accepts operands this cycle
- a  in  W  operand A {sign, exp, frac}
- b  in  W  operand B
- op  in  1  0 = a+b, 1 = a-b
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- s  out  W  result
- ovf  out  1  overflow: result rounded to infinity
- unf  out  1  underflow: nonzero result flushed to zero
- inv  out  1  invalid: NaN input, or inf-inf effective subtraction

Behaviour:
- Reset (async, rst_n=0):
  - All stage valid bits clear; out_valid=0; s=0; ovf=unf=inv=0.
  - Data registers need not reset except the output register.
  - Reset mid-operation discards all in-flight operations.
  - First acceptance is allowed on the first clk edge after rst_n deasserts.
- Flow control:
  - Global stall: adv = !out_valid || out_ready; in_ready = adv.
  - On adv, every stage register loads from its predecessor, including the valid bit.
  - When adv=0, all stages hold.
  - Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
  - s and flags stay stable while out_valid && !out_ready.
  - Latency 4 cycles from transfer in to out_valid with out_ready held high; throughput 1 per cycle. Results emerge in issue order.
- S1 (unpack/compare):
  - Effective sign of b = b.sign ^ op.
  - Exponent 0 means zero; subnormal inputs are flushed to signed zero (FTZ).
  - Detect inf (exp all ones, frac 0) and NaN (exp all ones, frac != 0).
  - Swap so that the larger-magnitude operand is X, comparing {exp,frac}. Ties make A the X operand.
  - Register the exponent difference d = expX - expY (EXP_W bits).
- S2 (align):
  - Significand = {1, frac}, extended with 3 bits G, R, S.
  - Shift Y right by d. S is the OR of all bits shifted past R.
  - If d >= FRAC_W+4, Y collapses to sticky only (S = 1 if Y is nonzero).
- S3 (add/sub):
  - Effective subtract when the two signs differ: X-Y, never negative thanks to the S1 swap.
  - Otherwise X+Y with carry-out.
  - Result sign = sign of X.
- S4 (normalise/round/pack):
  - Carry-out: shift right 1 (sticky-preserving), exp+1.
  - Otherwise: leading-zero count, shift left, exp-lzc.
  - Round-to-nearest-even on G/R/S; a rounding carry re-normalises and exp+1.
  - exp >= all-ones: s = ±inf, ovf=1.
  - exp <= 0 with nonzero magnitude: s = ±0, unf=1.
  - Exact-zero difference gives +0.
- Specials, with priority over arithmetic:
  - Any NaN, or inf-inf on effective subtraction: s = canonical quiet NaN {0, all ones, 1, 0...}, inv=1.
  - Otherwise any inf: s = that inf with its effective sign.
  - (+0)+(-0) = +0; (-0)+(-0) = -0.
- Flags are per-result, valid only with out_valid, and mutually exclusive.

Test Plan:
- Basic add: 1.0 + 1.0 (a = b = 0x3F800000, op=0), out_ready=1 -> s=0x40000000 exactly 4 cycles after acceptance, flags 0.
- Cancellation: 1.0 - 1.0 (0x3F800000 - 0x3F800000, op=1) -> s=0x00000000.
- Round-to-nearest-even ties:
  - 0x3F800000 + 0x33800000 -> s=0x3F800000.
  - 0x3F800001 + 0x33800000 -> s=0x3F800002.
- Overflow and invalid:
  - 0x7F7FFFFF + 0x7F7FFFFF -> s=0x7F800000, ovf=1.
  - 0x7F800000 - 0x7F800000 -> s=0x7FC00000, inv=1.
- Backpressure: stream 6 random operand pairs; out_ready=0 for 3 cycles mid-stream -> in_ready=0 while out_valid is stalled, no result lost or duplicated, order matches issue, each result matches the reference model.
- Reset mid-flight: pull rst_n low with 3 operations in flight -> out_valid=0 immediately; after release, a new 2.0+0.5 (0x40000000+0x3F000000) returns 0x40200000 with no stale output.
